// File: rtl/rv_pkg.sv
// Shared RV32 definitions used by instruction fetch, the control unit and
// later decode stages.
//   ILEN          instruction width
//   OP_*          major opcodes the decoder distinguishes
//   NOP_INSTR     canonical addi x0, x0, 0
//   fetch_state_t fetch FSM states
package rv_pkg;

  localparam int unsigned ILEN = 32;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {S_REQ, S_WAIT} fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory channel: valid/ready request, single-cycle response pulse.
//   master : fetch unit (drives request, receives response)
//   slave  : instruction memory
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = 32
) ();

  logic                     imem_req_valid;
  logic                     imem_req_ready;
  logic [XLEN-1:0]          imem_addr;
  logic                     imem_rsp_valid;
  logic [rv_pkg::ILEN-1:0]  imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/instr_fetch_unit_slot.sv
// One-entry IF/ID register holding the fetched instruction and its PC.
//   load/load_instr/load_pc : write a fresh instruction
//   flush                   : discard contents (redirect), beats load
//   id_ready                : decoder consumes the slot
//   if_valid/if_instr/if_pc : registered slot contents
//   if_opcode               : opcode field of if_instr for the decoder
module if_id_slot
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [ILEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            flush,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [ILEN-1:0] if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [6:0]      if_opcode
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      // A load in the same edge as a drain keeps the slot full.
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
    end else if (id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign if_valid  = valid_q;
  assign if_instr  = instr_q;
  assign if_pc     = pc_q;
  assign if_opcode = instr_q[6:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one request at a time to
// instruction memory and parks the response in the IF/ID slot.
//   clk, rst_n               clock, synchronous active-low reset
//   imem                     instruction-memory channel (master side)
//   redirect_valid/_pc       taken-branch redirect; flushes slot, kills in-flight fetch
//   if_valid/instr/pc/opcode IF/ID slot towards the decoder
//   id_ready                 decoder consumes the slot
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  instr_fetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic                      if_valid,
  output logic [ILEN-1:0]           if_instr,
  output logic [XLEN-1:0]           if_pc,
  output logic [6:0]                if_opcode,
  input  logic                      id_ready
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redirect_target;
  logic            kill_q, kill_d;
  logic            slot_free;
  logic            slot_load;
  logic            req_valid;

  // Requests only go out when the slot will be empty by the time data lands.
  assign slot_free       = !if_valid || id_ready;
  assign redirect_target = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    kill_d    = kill_q;
    slot_load = 1'b0;
    req_valid = 1'b0;
    case (state_q)
      S_REQ: begin
        req_valid = rst_n && slot_free && !redirect_valid;
        if (req_valid && imem.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
          if (!kill_q && !redirect_valid) begin
            slot_load = 1'b1;
            pc_d      = pc_q + XLEN'(4);
          end
        end
      end
      default: state_d = S_REQ;
    endcase
    if (redirect_valid) begin
      pc_d = redirect_target;
      // Response still owed by memory: remember to discard it.
      if (state_q == S_WAIT && !imem.imem_rsp_valid) kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_addr      = pc_q;

  if_id_slot #(
    .XLEN (XLEN)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (slot_load),
    .load_instr (imem.imem_rsp_data),
    .load_pc    (pc_q),
    .flush      (redirect_valid),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_opcode  (if_opcode)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus, a memory model with
// programmable latency, and a stream-level reference model checked every cycle.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;

  logic        if_valid2;
  logic [31:0] if_instr2;
  logic [31:0] if_pc2;
  logic [6:0]  if_opcode2;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mem_lat  = 1;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.XLEN(32)) ifc ();
  instr_fetch_unit_if #(.XLEN(32)) ifc2 ();

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (ifc.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_opcode      (if_opcode),
    .id_ready       (id_ready)
  );

  // Second instance exercises PC wrap-around from the top of the address space.
  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (ifc2.master),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (if_valid2),
    .if_instr       (if_instr2),
    .if_pc          (if_pc2),
    .if_opcode      (if_opcode2),
    .id_ready       (1'b1)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h00A0_0093;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Memory for the main DUT: response fires mem_lat cycles after acceptance.
  logic        acc_n = 1'b0;
  logic [31:0] acc_addr = '0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;

  always @(negedge clk) begin
    acc_n    = ifc.imem_req_valid && ifc.imem_req_ready;
    acc_addr = ifc.imem_addr;
  end

  always @(posedge clk) begin
    #1;
    ifc.imem_rsp_valid = 1'b0;
    if (acc_n) begin
      pend  = 1'b1;
      cnt   = mem_lat;
      paddr = acc_addr;
    end
    if (pend) begin
      if (cnt <= 1) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = mem_word(paddr);
        pend               = 1'b0;
      end else begin
        cnt--;
      end
    end
  end

  // Memory for the wrap DUT: always ready, one-cycle latency.
  logic        acc2 = 1'b0;
  logic [31:0] addr2 = '0;

  always @(negedge clk) begin
    acc2  = ifc2.imem_req_valid && ifc2.imem_req_ready;
    addr2 = ifc2.imem_addr;
  end

  always @(posedge clk) begin
    #1;
    ifc2.imem_rsp_valid = acc2;
    ifc2.imem_rsp_data  = mem_word(addr2);
  end

  // Reference model: the next address to be requested and the PC of the next
  // instruction to be delivered, both restarted by reset or redirect.
  logic [31:0] exp_req = '0;
  logic [31:0] exp_deliv = '0;
  logic [31:0] exp_w;
  logic [31:0] prev_instr = '0;
  int          outstanding = 0;
  bit          prev_flush = 1'b0;
  bit          prev_hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("req_valid_in_reset", {31'b0, ifc.imem_req_valid}, 32'd0);
      exp_req     = 32'h0;
      exp_deliv   = 32'h0;
      outstanding = 0;
      prev_flush  = 1'b1;
      prev_hold   = 1'b0;
    end else begin
      if (prev_flush) check("flushed_slot_empty", {31'b0, if_valid}, 32'd0);
      if (prev_hold) begin
        check("held_valid", {31'b0, if_valid}, 32'd1);
        check("held_instr", if_instr, prev_instr);
      end
      if (ifc.imem_req_valid) begin
        check("req_addr", ifc.imem_addr, exp_req);
        check("one_outstanding", 32'(outstanding), 32'd0);
      end
      if (if_valid) begin
        exp_w = mem_word(exp_deliv);
        check("slot_pc", if_pc, exp_deliv);
        check("slot_instr", if_instr, exp_w);
        check("slot_opcode", {25'b0, if_opcode}, {25'b0, exp_w[6:0]});
      end
      prev_flush = redirect_valid;
      prev_hold  = if_valid && !id_ready && !redirect_valid;
      prev_instr = if_instr;
      if (ifc.imem_rsp_valid && outstanding > 0) outstanding--;
      if (redirect_valid) begin
        exp_req   = redirect_pc & ~32'd3;
        exp_deliv = redirect_pc & ~32'd3;
      end else begin
        if (ifc.imem_req_valid && ifc.imem_req_ready) begin
          exp_req = exp_req + 32'd4;
          outstanding++;
        end
        if (if_valid && id_ready) exp_deliv = exp_deliv + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    id_ready            = 1'b1;
    ifc.imem_req_ready  = 1'b1;
    ifc.imem_rsp_valid  = 1'b0;
    ifc.imem_rsp_data   = '0;
    ifc2.imem_req_ready = 1'b1;
    ifc2.imem_rsp_valid = 1'b0;
    ifc2.imem_rsp_data  = '0;

    tick();
    tick();
    @(negedge clk);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    tick();
    rst_n = 1'b1;                                   // C0

    @(negedge clk);
    check("c0_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    check("c0_addr", ifc.imem_addr, 32'h0);
    tick();                                         // C1
    tick();                                         // C2
    @(negedge clk);
    check("c2_if_valid", {31'b0, if_valid}, 32'd1);
    check("c2_if_pc", if_pc, 32'h0);
    check("c2_if_instr", if_instr, 32'h00A0_0093);
    check("c2_opcode", {25'b0, if_opcode}, {25'b0, 7'b0010011});
    check("c2_addr", ifc.imem_addr, 32'h4);
    check("wrap_first_pc", if_pc2, 32'hFFFF_FFFC);
    check("wrap_first_instr", if_instr2, 32'hFF5F_FF6F);
    check("wrap_next_addr", ifc2.imem_addr, 32'h0);
    tick();                                         // C3
    tick();                                         // C4
    id_ready = 1'b0;
    @(negedge clk);
    check("c4_if_pc", if_pc, 32'h4);
    check("c4_no_req", {31'b0, ifc.imem_req_valid}, 32'd0);
    check("wrap_second_pc", if_pc2, 32'h0);
    tick();                                         // C5
    tick();                                         // C6
    @(negedge clk);
    check("c6_held_valid", {31'b0, if_valid}, 32'd1);
    check("c6_held_instr", if_instr, 32'h00A0_0097);
    check("c6_no_req", {31'b0, ifc.imem_req_valid}, 32'd0);
    tick();                                         // C7
    id_ready = 1'b1;
    mem_lat  = 3;
    @(negedge clk);
    check("c7_req_same_cycle", {31'b0, ifc.imem_req_valid}, 32'd1);
    check("c7_addr", ifc.imem_addr, 32'h8);
    tick();                                         // C8
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();                                         // C9
    redirect_valid = 1'b0;
    mem_lat        = 1;
    @(negedge clk);
    check("c9_flushed", {31'b0, if_valid}, 32'd0);
    check("c9_waiting", {31'b0, ifc.imem_req_valid}, 32'd0);
    tick();                                         // C10
    @(negedge clk);
    check("c10_killed_wait", {31'b0, ifc.imem_req_valid}, 32'd0);
    tick();                                         // C11
    @(negedge clk);
    check("c11_drop_valid", {31'b0, if_valid}, 32'd0);
    check("c11_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    check("c11_addr", ifc.imem_addr, 32'h100);
    tick();                                         // C12
    tick();                                         // C13
    @(negedge clk);
    check("c13_if_pc", if_pc, 32'h100);
    check("c13_if_instr", if_instr, 32'h00A0_0193);
    check("c13_addr", ifc.imem_addr, 32'h104);
    tick();                                         // C14: redirect with response
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();                                         // C15
    redirect_valid = 1'b0;
    @(negedge clk);
    check("c15_if_valid", {31'b0, if_valid}, 32'd0);
    check("c15_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    check("c15_addr", ifc.imem_addr, 32'h200);
    tick();                                         // C16
    tick();                                         // C17
    id_ready = 1'b0;
    @(negedge clk);
    check("c17_if_valid", {31'b0, if_valid}, 32'd1);
    check("c17_if_pc", if_pc, 32'h200);
    check("c17_if_instr", if_instr, 32'h00A0_0293);
    tick();                                         // C18: redirect while stalled
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();                                         // C19
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    mem_lat        = 3;
    @(negedge clk);
    check("c19_flush_stalled", {31'b0, if_valid}, 32'd0);
    check("c19_addr", ifc.imem_addr, 32'h300);
    tick();                                         // C20: reset in S_WAIT
    rst_n = 1'b0;
    tick();                                         // C21
    rst_n              = 1'b1;
    ifc.imem_req_ready = 1'b0;
    mem_lat            = 1;
    tick();                                         // C22: stale response
    @(negedge clk);
    check("c22_stale_present", {31'b0, ifc.imem_rsp_valid}, 32'd1);
    check("c22_addr", ifc.imem_addr, 32'h0);
    tick();                                         // C23
    ifc.imem_req_ready = 1'b1;
    @(negedge clk);
    check("c23_stale_ignored", {31'b0, if_valid}, 32'd0);
    check("c23_req_valid", {31'b0, ifc.imem_req_valid}, 32'd1);
    check("c23_addr", ifc.imem_addr, 32'h0);
    tick();                                         // C24
    tick();                                         // C25
    @(negedge clk);
    check("c25_if_pc", if_pc, 32'h0);
    check("c25_if_instr", if_instr, 32'h00A0_0093);
    tick();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
